// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Round-robin arbiter that shares one eight-digit seven-segment display
// between four requesters. Each grant is held for a minimum page time,
// and the granted client's BCD word and dot mask are registered toward
// the display controller. With no requester active, an idle pattern is shown.

module seg_display_arbiter #(
    parameter int          FREQUENCY_IN = 50_000_000,
    parameter int          HOLD_MS      = 1000,
    parameter logic [31:0] IDLE_BCD     = 32'hFFFF_FFFF,
    parameter logic [7:0]  IDLE_DOT     = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_in,
    input  logic [31:0] bcd0_in,
    input  logic [31:0] bcd1_in,
    input  logic [31:0] bcd2_in,
    input  logic [31:0] bcd3_in,
    input  logic [7:0]  dot0_in,
    input  logic [7:0]  dot1_in,
    input  logic [7:0]  dot2_in,
    input  logic [7:0]  dot3_in,
    output logic [3:0]  grant_out,
    output logic [31:0] bcdCoder_out,
    output logic [7:0]  hasDot_out,
    output logic        active_out
);

    // Page time in clock cycles, never allowed to drop below one cycle
    localparam int HOLD_RAW    = FREQUENCY_IN / 1000 * HOLD_MS;
    localparam int HOLD_CYCLES = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t           r_state;
    logic [3:0]       r_grant;
    logic [31:0]      r_bcd;
    logic [7:0]       r_dot;
    logic             r_active;
    logic [1:0]       r_rrPtr;
    logic [1:0]       r_owner;
    logic [CNT_W-1:0] r_holdCnt;

    logic [31:0] w_bcd [4];
    logic [7:0]  w_dot [4];
    logic [1:0]  w_pick;
    logic        w_anyReq;
    logic        w_otherReq;
    logic        w_ownerReq;

    assign w_bcd[0] = bcd0_in;
    assign w_bcd[1] = bcd1_in;
    assign w_bcd[2] = bcd2_in;
    assign w_bcd[3] = bcd3_in;
    assign w_dot[0] = dot0_in;
    assign w_dot[1] = dot1_in;
    assign w_dot[2] = dot2_in;
    assign w_dot[3] = dot3_in;

    assign w_anyReq   = |req_in;
    assign w_otherReq = |(req_in & ~r_grant);
    assign w_ownerReq = req_in[r_owner];

    // Round-robin pick: scanning from the far end backwards leaves the
    // closest requester to r_rrPtr as the final assignment
    always_comb begin
        w_pick = r_rrPtr;
        for (int k = 3; k >= 0; k--) begin
            if (req_in[r_rrPtr + 2'(k)]) begin
                w_pick = r_rrPtr + 2'(k);
            end
        end
    end

    // Arbitration FSM; every output is a register so the display sees clean levels
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= 4'b0000;
            r_bcd     <= IDLE_BCD;
            r_dot     <= IDLE_DOT;
            r_active  <= 1'b0;
            r_rrPtr   <= 2'd0;
            r_owner   <= 2'd0;
            r_holdCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_state   <= ST_HOLD;
                        r_owner   <= w_pick;
                        r_grant   <= 4'b0001 << w_pick;
                        r_bcd     <= w_bcd[w_pick];
                        r_dot     <= w_dot[w_pick];
                        r_active  <= 1'b1;
                        r_holdCnt <= HOLD_LOAD;
                        r_rrPtr   <= w_pick + 2'd1;
                    end else begin
                        r_bcd <= IDLE_BCD;
                        r_dot <= IDLE_DOT;
                    end
                end
                ST_HOLD: begin
                    if (!w_ownerReq) begin
                        if (w_anyReq) begin
                            r_owner   <= w_pick;
                            r_grant   <= 4'b0001 << w_pick;
                            r_bcd     <= w_bcd[w_pick];
                            r_dot     <= w_dot[w_pick];
                            r_active  <= 1'b1;
                            r_holdCnt <= HOLD_LOAD;
                            r_rrPtr   <= w_pick + 2'd1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_grant   <= 4'b0000;
                            r_bcd     <= IDLE_BCD;
                            r_dot     <= IDLE_DOT;
                            r_active  <= 1'b0;
                            r_holdCnt <= '0;
                        end
                    end else if ((r_holdCnt == '0) && w_otherReq) begin
                        r_owner   <= w_pick;
                        r_grant   <= 4'b0001 << w_pick;
                        r_bcd     <= w_bcd[w_pick];
                        r_dot     <= w_dot[w_pick];
                        r_active  <= 1'b1;
                        r_holdCnt <= HOLD_LOAD;
                        r_rrPtr   <= w_pick + 2'd1;
                    end else begin
                        r_bcd <= w_bcd[r_owner];
                        r_dot <= w_dot[r_owner];
                        if (r_holdCnt != '0) begin
                            r_holdCnt <= r_holdCnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_out    = r_grant;
    assign bcdCoder_out = r_bcd;
    assign hasDot_out   = r_dot;
    assign active_out   = r_active;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter
// Directed bench for the display arbiter with an 8-cycle page time.
// Expected output words are queued as each step is driven and compared
// one cycle later, after the clock edge that should produce them.

module tb_seg_display_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_in;
    logic [31:0] bcd0, bcd1, bcd2, bcd3;
    logic [7:0]  dot0, dot1, dot2, dot3;
    logic [3:0]  grant_out;
    logic [31:0] bcdCoder_out;
    logic [7:0]  hasDot_out;
    logic        active_out;

    typedef struct {
        string       tag;
        logic [3:0]  grant;
        logic [31:0] bcd;
        logic [7:0]  dot;
        logic        active;
    } expect_t;

    expect_t expQ [$];
    int assertCount = 0;
    int failCount   = 0;

    seg_display_arbiter #(
        .FREQUENCY_IN(4000),
        .HOLD_MS     (2),
        .IDLE_BCD    (32'hFFFF_FFFF),
        .IDLE_DOT    (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .bcd0_in     (bcd0),
        .bcd1_in     (bcd1),
        .bcd2_in     (bcd2),
        .bcd3_in     (bcd3),
        .dot0_in     (dot0),
        .dot1_in     (dot1),
        .dot2_in     (dot2),
        .dot3_in     (dot3),
        .grant_out   (grant_out),
        .bcdCoder_out(bcdCoder_out),
        .hasDot_out  (hasDot_out),
        .active_out  (active_out)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] clientBcd(input int c);
        case (c)
            0:       return bcd0;
            1:       return bcd1;
            2:       return bcd2;
            default: return bcd3;
        endcase
    endfunction

    function automatic logic [7:0] clientDot(input int c);
        case (c)
            0:       return dot0;
            1:       return dot1;
            2:       return dot2;
            default: return dot3;
        endcase
    endfunction

    // Pops the oldest expectation and compares every output field against it
    task automatic checkOutput();
        expect_t e;
        assertCount++;
        assert (expQ.size() != 0) else begin
            failCount++;
            $error("[TB] FAIL scoreboard_empty: got 0 entries, required 1");
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            assertCount++;
            assert (grant_out === e.grant) else begin
                failCount++;
                $error("[TB] FAIL %s.grant: got %b required %b", e.tag, grant_out, e.grant);
            end
            assertCount++;
            assert (bcdCoder_out === e.bcd) else begin
                failCount++;
                $error("[TB] FAIL %s.bcd: got %h required %h", e.tag, bcdCoder_out, e.bcd);
            end
            assertCount++;
            assert (hasDot_out === e.dot) else begin
                failCount++;
                $error("[TB] FAIL %s.dot: got %h required %h", e.tag, hasDot_out, e.dot);
            end
            assertCount++;
            assert (active_out === e.active) else begin
                failCount++;
                $error("[TB] FAIL %s.active: got %b required %b", e.tag, active_out, e.active);
            end
        end
    endtask

    // Drives one cycle of inputs, queues the expected result of the next edge, then checks it
    task automatic applyStimulus(input logic rstV, input logic [3:0] reqV, input string tag,
                                 input int client);
        expect_t e;
        rst    = rstV;
        req_in = reqV;
        e.tag  = tag;
        if (client < 0) begin
            e.grant  = 4'b0000;
            e.bcd    = 32'hFFFF_FFFF;
            e.dot    = 8'h00;
            e.active = 1'b0;
        end else begin
            e.grant  = 4'b0001 << client;
            e.bcd    = clientBcd(client);
            e.dot    = clientDot(client);
            e.active = 1'b1;
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Directed sequence; client -1 denotes the idle pattern
    initial begin
        int rot [4];
        rst    = 1'b0;
        req_in = 4'hF;
        bcd0 = 32'h1111_0000; dot0 = 8'h01;
        bcd1 = 32'h2222_0001; dot1 = 8'h02;
        bcd2 = 32'h1234_5678; dot2 = 8'h10;
        bcd3 = 32'h4444_0003; dot3 = 8'h08;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'hF, "reset", -1);
        applyStimulus(1'b1, 4'b0001, "post_reset_grant0", 0);
        applyStimulus(1'b1, 4'b0000, "release_to_idle", -1);

        applyStimulus(1'b1, 4'b0100, "single_grant2", 2);
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, 4'b0100, "single_hold", 2);
        bcd2 = 32'h8765_4321;
        applyStimulus(1'b1, 4'b0100, "live_update", 2);
        applyStimulus(1'b1, 4'b0000, "idle_before_rot", -1);

        rot[0] = 3; rot[1] = 0; rot[2] = 1; rot[3] = 3;
        for (int n = 0; n < 32; n++) applyStimulus(1'b1, 4'b1011, "rotation", rot[n / 8]);

        applyStimulus(1'b1, 4'b0010, "grant1_after_release", 1);
        applyStimulus(1'b1, 4'b0010, "hold1_c2", 1);
        applyStimulus(1'b1, 4'b0010, "hold1_c3", 1);
        applyStimulus(1'b1, 4'b1000, "early_release_to3", 3);
        applyStimulus(1'b1, 4'b0010, "regrant1", 1);
        applyStimulus(1'b1, 4'b0010, "hold1", 1);
        applyStimulus(1'b1, 4'b0000, "early_release_idle", -1);

        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 4'b0001, "sole_client0", 0);
        applyStimulus(1'b1, 4'b0101, "newcomer2", 2);

        applyStimulus(1'b1, 4'b1000, "grant3", 3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1000, "hold3", 3);
        applyStimulus(1'b0, 4'b1000, "reset_mid_hold", -1);
        applyStimulus(1'b1, 4'b1001, "rrptr_cleared", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
